// File: rtl/regfile_syscall.sv
// -----------------------------------------------------------------------------
// regfile_syscall
//
// Integer register file for the single-cycle core with an attached
// environment-call service unit. Two combinational read ports, one
// synchronous write port, optional same-cycle write forwarding, and a small
// FSM that services print / read / exit / test-case ecalls. While a
// multi-cycle service is outstanding the core is stalled.
//
// Ports:
//   clk, reset               clock (rising edge), asynchronous active-low reset
//   rs1, rs2, rd             read / write register addresses
//   write_data, reg_write    writeback data and enable
//   ecall                    current instruction is ECALL
//   read_data1, read_data2   combinational read data
//   stall                    core holds PC and discards writeback
//   io_in_*                  input service handshake (block is the sink)
//   io_out_*                 print service handshake (block is the source)
//   test_case                value loaded into a0 by the test-case service
//   led_out                  [0] halted, [1] test-case pulse, [7] input pulse
//   halted                   exit service taken (sticky until reset)
// -----------------------------------------------------------------------------
module regfile_syscall #(
    parameter int                XLEN      = 32,
    parameter int                NREG      = 32,
    parameter bit                BYPASS    = 1'b1,
    parameter logic [XLEN-1:0]   SP_INIT   = 'h7fff,
    parameter logic [XLEN-1:0]   GP_INIT   = 'h1000,
    parameter int                LED_PULSE = 4,
    localparam int               AW        = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] write_data,
    input  logic            reg_write,
    input  logic            ecall,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2,
    output logic            stall,
    input  logic [XLEN-1:0] io_in_data,
    input  logic            io_in_valid,
    output logic            io_in_ready,
    output logic [XLEN-1:0] io_out_data,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    input  logic [XLEN-1:0] test_case,
    output logic [7:0]      led_out,
    output logic            halted
);

    // Service codes held in a7
    localparam logic [XLEN-1:0] SYS_PRINT = XLEN'(1);
    localparam logic [XLEN-1:0] SYS_READ  = XLEN'(5);
    localparam logic [XLEN-1:0] SYS_EXIT  = XLEN'(10);
    localparam logic [XLEN-1:0] SYS_TEST  = XLEN'(11);

    localparam int A0_IDX = 10;
    localparam int A7_IDX = 17;

    // Counter must hold LED_PULSE itself
    localparam int CW = $clog2(LED_PULSE + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_IN,
        ST_WAIT_OUT,
        ST_HALT
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_regs [NREG];
    logic [XLEN-1:0] r_io_out_data;
    logic            r_io_out_valid;
    logic            r_io_in_ready;
    logic            r_halted;
    logic [CW-1:0]   r_led7_cnt;
    logic [CW-1:0]   r_led1_cnt;

    logic [XLEN-1:0] w_a0;
    logic [XLEN-1:0] w_a7;
    logic            w_ecall_idle;
    logic            w_svc_stalls;
    logic            w_stall;
    logic            w_reg_we;
    logic            w_fwd;
    logic            w_in_fire;
    logic            w_tc_fire;
    logic            w_a0_sys_we;
    logic [XLEN-1:0] w_a0_sys_data;

    // ------------------------------------------------------------------
    // Register aliases. A 16-entry file has no x17, so a7 reads as zero
    // there and only the non-stalling "no operation" path is reachable.
    // ------------------------------------------------------------------
    assign w_a0 = r_regs[A0_IDX];

    generate
        if (NREG > A7_IDX) begin : g_a7
            assign w_a7 = r_regs[A7_IDX];
        end else begin : g_no_a7
            assign w_a7 = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stall and write qualification
    // ------------------------------------------------------------------
    assign w_ecall_idle = ecall && (r_state == ST_IDLE);
    assign w_svc_stalls = (w_a7 == SYS_PRINT) || (w_a7 == SYS_READ) ||
                          (w_a7 == SYS_EXIT);
    assign w_stall      = (r_state != ST_IDLE) || (w_ecall_idle && w_svc_stalls);
    assign stall        = w_stall;

    // ecall wins over a same-cycle writeback, even when the service is a
    // single-cycle one that does not stall.
    assign w_reg_we = reg_write && (rd != '0) && !w_stall && !ecall;

    // Forward only what will actually land in the file on this edge, so a
    // discarded writeback is never visible on the read ports.
    assign w_fwd = BYPASS && w_reg_we;

    // a0 updates from the services: input handshake or test-case load
    assign w_in_fire     = (r_state == ST_WAIT_IN) && io_in_valid && r_io_in_ready;
    assign w_tc_fire     = w_ecall_idle && (w_a7 == SYS_TEST);
    assign w_a0_sys_we   = w_in_fire || w_tc_fire;
    assign w_a0_sys_data = w_in_fire ? io_in_data : test_case;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        logic [XLEN-1:0] val;
        if (addr == '0) begin
            val = '0;
        end else if (w_fwd && (rd == addr)) begin
            val = write_data;
        end else begin
            val = r_regs[addr];
        end
        return val;
    endfunction

    assign read_data1 = read_port(rs1);
    assign read_data2 = read_port(rs2);

    // ------------------------------------------------------------------
    // Register storage. x0 is reset to zero and never written because
    // w_reg_we excludes rd==0.
    // ------------------------------------------------------------------
    function automatic logic [XLEN-1:0] reset_value(input int idx);
        logic [XLEN-1:0] val;
        if (idx == 2) begin
            val = SP_INIT;
        end else if (idx == 3) begin
            val = GP_INIT;
        end else begin
            val = '0;
        end
        return val;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= reset_value(i);
            end
        end else begin
            if (w_reg_we) begin
                r_regs[rd] <= write_data;
            end
            // Service writes to a0 only happen with ecall or stall active,
            // so they never collide with a writeback.
            if (w_a0_sys_we) begin
                r_regs[A0_IDX] <= w_a0_sys_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Syscall FSM with registered handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_io_out_data  <= '0;
            r_io_out_valid <= 1'b0;
            r_io_in_ready  <= 1'b0;
            r_halted       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ecall) begin
                        if (w_a7 == SYS_PRINT) begin
                            r_io_out_data  <= w_a0;
                            r_io_out_valid <= 1'b1;
                            r_state        <= ST_WAIT_OUT;
                        end else if (w_a7 == SYS_READ) begin
                            r_io_in_ready  <= 1'b1;
                            r_state        <= ST_WAIT_IN;
                        end else if (w_a7 == SYS_EXIT) begin
                            r_halted       <= 1'b1;
                            r_state        <= ST_HALT;
                        end
                        // SYS_TEST and unknown codes stay in IDLE
                    end
                end
                ST_WAIT_IN: begin
                    if (io_in_valid) begin
                        r_io_in_ready <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_WAIT_OUT: begin
                    if (io_out_ready) begin
                        r_io_out_valid <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // LED pulse stretchers: load on trigger, count down to zero
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led7_cnt <= '0;
            r_led1_cnt <= '0;
        end else begin
            if (w_in_fire) begin
                r_led7_cnt <= CW'(LED_PULSE);
            end else if (r_led7_cnt != '0) begin
                r_led7_cnt <= r_led7_cnt - 1'b1;
            end

            if (w_tc_fire) begin
                r_led1_cnt <= CW'(LED_PULSE);
            end else if (r_led1_cnt != '0) begin
                r_led1_cnt <= r_led1_cnt - 1'b1;
            end
        end
    end

    assign io_out_data  = r_io_out_data;
    assign io_out_valid = r_io_out_valid;
    assign io_in_ready  = r_io_in_ready;
    assign halted       = r_halted;
    assign led_out      = {(r_led7_cnt != '0), 5'b00000, (r_led1_cnt != '0), r_halted};

endmodule

// File: tb/tb_regfile_syscall.sv
module tb_regfile_syscall;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] write_data;
    logic        reg_write;
    logic        ecall;
    logic [31:0] read_data1, read_data2;
    logic        stall;
    logic [31:0] io_in_data;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [31:0] io_out_data;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] test_case;
    logic [7:0]  led_out;
    logic        halted;

    // Second instance without forwarding, sharing all inputs
    logic [31:0] nb_read_data1, nb_read_data2;
    logic        nb_stall, nb_io_in_ready, nb_io_out_valid, nb_halted;
    logic [31:0] nb_io_out_data;
    logic [7:0]  nb_led_out;

    int n_total = 0;
    int n_pass  = 0;

    regfile_syscall #(.BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
        .write_data(write_data), .reg_write(reg_write), .ecall(ecall),
        .read_data1(read_data1), .read_data2(read_data2), .stall(stall),
        .io_in_data(io_in_data), .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
        .io_out_data(io_out_data), .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
        .test_case(test_case), .led_out(led_out), .halted(halted)
    );

    regfile_syscall #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
        .write_data(write_data), .reg_write(reg_write), .ecall(ecall),
        .read_data1(nb_read_data1), .read_data2(nb_read_data2), .stall(nb_stall),
        .io_in_data(io_in_data), .io_in_valid(io_in_valid), .io_in_ready(nb_io_in_ready),
        .io_out_data(nb_io_out_data), .io_out_valid(nb_io_out_valid), .io_out_ready(io_out_ready),
        .test_case(test_case), .led_out(nb_led_out), .halted(nb_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
            $display("check %s: got %h expected %h ok", name, act, exp);
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Write one register; returns at a falling edge with reg_write low
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        rd = a;
        write_data = d;
        reg_write = 1'b1;
        @(negedge clk);
        reg_write = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  v_rs1;
        logic [4:0]  v_rs2;
        logic [4:0]  v_rd;
        logic        v_we;
        logic [31:0] v_wd;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] e_nb1;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [31:0] reset_val(input int idx);
        if (idx == 2) return 32'h7fff;
        if (idx == 3) return 32'h1000;
        return 32'h0;
    endfunction

    initial begin
        int cnt;
        logic seen;

        vecs[0]  = '{5'd2,  5'd3,  5'd0,  1'b0, 32'h0,        32'h7fff,     32'h1000,     32'h7fff};
        vecs[1]  = '{5'd0,  5'd1,  5'd0,  1'b1, 32'h5,        32'h0,        32'h0,        32'h0};
        vecs[2]  = '{5'd0,  5'd4,  5'd0,  1'b0, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[3]  = '{5'd5,  5'd5,  5'd5,  1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        vecs[4]  = '{5'd5,  5'd6,  5'd0,  1'b0, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        vecs[5]  = '{5'd6,  5'd2,  5'd6,  1'b1, 32'h12345678, 32'h12345678, 32'h7fff,     32'h0};
        vecs[6]  = '{5'd10, 5'd17, 5'd10, 1'b1, 32'h7,        32'h7,        32'h0,        32'h0};
        vecs[7]  = '{5'd31, 5'd1,  5'd31, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h0};
        vecs[8]  = '{5'd31, 5'd30, 5'd0,  1'b0, 32'h0,        32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5};
        vecs[9]  = '{5'd3,  5'd2,  5'd2,  1'b1, 32'h1,        32'h1000,     32'h1,        32'h1000};
        vecs[10] = '{5'd2,  5'd10, 5'd0,  1'b0, 32'h0,        32'h1,        32'h7,        32'h1};
        vecs[11] = '{5'd1,  5'd0,  5'd1,  1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        32'h0};
        vecs[12] = '{5'd1,  5'd6,  5'd0,  1'b0, 32'h0,        32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D};

        reset = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; write_data = '0; reg_write = 1'b0;
        ecall = 1'b0; io_in_data = '0; io_in_valid = 1'b0; io_out_ready = 1'b0;
        test_case = '0;

        // ---------------- reset state ----------------
        #1;
        check1("rst_stall", stall, 1'b0);
        check1("rst_out_valid", io_out_valid, 1'b0);
        check("rst_out_data", io_out_data, 32'h0);
        check1("rst_in_ready", io_in_ready, 1'b0);
        check("rst_led", {24'h0, led_out}, 32'h0);
        check1("rst_halted", halted, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            check($sformatf("rst_x%0d_p1", i), read_data1, reset_val(i));
            check($sformatf("rst_x%0d_p2", i), read_data2, reset_val(31 - i));
        end

        // ---------------- table-driven read/write ----------------
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rs1 = vecs[i].v_rs1;
            rs2 = vecs[i].v_rs2;
            rd = vecs[i].v_rd;
            reg_write = vecs[i].v_we;
            write_data = vecs[i].v_wd;
            #1;
            check($sformatf("vec%0d_rd1", i), read_data1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), read_data2, vecs[i].e2);
            check($sformatf("vec%0d_nb_rd1", i), nb_read_data1, vecs[i].e_nb1);
        end
        @(negedge clk);
        reg_write = 1'b0;

        // ---------------- input service ----------------
        wr(5'd17, 32'd5);
        ecall = 1'b1;
        rd = 5'd6; write_data = 32'hFFFFFFFF; reg_write = 1'b1;
        rs1 = 5'd10; rs2 = 5'd6;
        #1;
        check1("in_stall_ecall", stall, 1'b1);
        check1("in_ready_pre", io_in_ready, 1'b0);
        @(negedge clk);
        ecall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check1($sformatf("in_wait%0d_stall", k), stall, 1'b1);
            check1($sformatf("in_wait%0d_ready", k), io_in_ready, 1'b1);
            check($sformatf("in_wait%0d_x6", k), read_data2, 32'h12345678);
            @(negedge clk);
        end
        io_in_valid = 1'b1; io_in_data = 32'd42;
        #1;
        check1("in_hs_stall", stall, 1'b1);
        check1("in_hs_led7", led_out[7], 1'b0);
        @(negedge clk);
        io_in_valid = 1'b0; io_in_data = '0; reg_write = 1'b0;
        #1;
        check1("in_done_stall", stall, 1'b0);
        check1("in_done_ready", io_in_ready, 1'b0);
        check("in_done_a0", read_data1, 32'd42);
        check("in_done_x6", read_data2, 32'h12345678);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (led_out[7]) cnt++;
            @(negedge clk);
            #1;
        end
        check("in_led7_len", 32'(cnt), 32'd4);

        // ---------------- output service ----------------
        wr(5'd10, 32'd7);
        wr(5'd17, 32'd1);
        ecall = 1'b1;
        #1;
        check1("out_stall_ecall", stall, 1'b1);
        check1("out_valid_pre", io_out_valid, 1'b0);
        @(negedge clk);
        ecall = 1'b0; io_out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check1($sformatf("out_hold%0d_valid", k), io_out_valid, 1'b1);
            check($sformatf("out_hold%0d_data", k), io_out_data, 32'd7);
            check1($sformatf("out_hold%0d_stall", k), stall, 1'b1);
            @(negedge clk);
        end
        io_out_ready = 1'b1;
        #1;
        check1("out_hs_valid", io_out_valid, 1'b1);
        check1("out_hs_stall", stall, 1'b1);
        @(negedge clk);
        io_out_ready = 1'b0;
        #1;
        check1("out_done_valid", io_out_valid, 1'b0);
        check1("out_done_stall", stall, 1'b0);

        // ---------------- test-case service ----------------
        test_case = 32'd3;
        wr(5'd17, 32'd11);
        ecall = 1'b1; rs1 = 5'd10;
        #1;
        check1("tc_stall_ecall", stall, 1'b0);
        @(negedge clk);
        ecall = 1'b0;
        #1;
        check("tc_a0", read_data1, 32'd3);
        cnt = 0; seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (led_out[1]) cnt++;
            if (stall) seen = 1'b1;
            @(negedge clk);
            #1;
        end
        check("tc_led1_len", 32'(cnt), 32'd4);
        check1("tc_no_stall", seen, 1'b0);

        // ---------------- exit service ----------------
        wr(5'd17, 32'd10);
        ecall = 1'b1;
        #1;
        check1("halt_stall_ecall", stall, 1'b1);
        @(negedge clk);
        ecall = 1'b0;
        rd = 5'd5; write_data = 32'h1111; reg_write = 1'b1; rs1 = 5'd5;
        #1;
        check1("halt_halted", halted, 1'b1);
        check1("halt_led0", led_out[0], 1'b1);
        check1("halt_stall", stall, 1'b1);
        check("halt_x5_nofwd", read_data1, 32'hDEADBEEF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ecall = (k == 1);
            #1;
            check1($sformatf("halt_sticky%0d_stall", k), stall, 1'b1);
            check1($sformatf("halt_sticky%0d_halted", k), halted, 1'b1);
        end
        @(negedge clk);
        ecall = 1'b0; reg_write = 1'b0;
        #1;
        check("halt_x5_kept", read_data1, 32'hDEADBEEF);

        // ---------------- reset out of HALT ----------------
        @(negedge clk);
        reset = 1'b0;
        #1;
        check1("rst2_halted", halted, 1'b0);
        check1("rst2_stall", stall, 1'b0);
        check("rst2_led", {24'h0, led_out}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // io_in_valid outside WAIT_IN is ignored
        rs1 = 5'd10;
        io_in_valid = 1'b1; io_in_data = 32'd99;
        @(negedge clk);
        io_in_valid = 1'b0; io_in_data = '0;
        #1;
        check("stray_in_a0", read_data1, 32'h0);
        check1("stray_in_ready", io_in_ready, 1'b0);

        // ---------------- reset in WAIT_OUT ----------------
        wr(5'd10, 32'd9);
        wr(5'd17, 32'd1);
        ecall = 1'b1;
        @(negedge clk);
        ecall = 1'b0;
        #1;
        check1("mid_valid_before", io_out_valid, 1'b1);
        check("mid_data_before", io_out_data, 32'd9);
        reset = 1'b0;
        rs1 = 5'd10; rs2 = 5'd2;
        #1;
        check1("mid_valid_rst", io_out_valid, 1'b0);
        check1("mid_stall_rst", stall, 1'b0);
        check("mid_data_rst", io_out_data, 32'h0);
        check("mid_a0_rst", read_data1, 32'h0);
        check("mid_sp_rst", read_data2, 32'h7fff);
        @(negedge clk);
        reset = 1'b1;
        rs2 = 5'd17;
        #1;
        check1("mid_stall_rel", stall, 1'b0);
        check1("mid_valid_rel", io_out_valid, 1'b0);
        check("mid_a7_rel", read_data2, 32'h0);
        @(negedge clk);
        #1;
        check1("mid_stall_idle", stall, 1'b0);
        check1("mid_ready_idle", io_in_ready, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
